// File: rtl/ychip_run_ctrl.sv
// Run/step sequencer for the single-cycle yChip: loads the entry point, then gates execute cycles.
// Optional breakpoint support is compiled in when RUN_CTRL_BREAK_EN is defined.
module ychip_run_ctrl #(
  parameter logic [31:0] HALT_INS = 32'h1000FFFF,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step_mode,
  input  logic             stop,
  input  logic             step,
  input  logic [31:0]      entry_in,
  input  logic [CNT_W-1:0] max_cycles,
  input  logic [31:0]      ins,
  input  logic [31:0]      pc,
  input  logic [31:0]      bp_addr,
  output logic [31:0]      entry_point,
  output logic             int_out,
  output logic             cpu_ce,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_PAUSE,
    S_STEP,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] max_q;
  logic             step_mode_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             is_halt;
  logic             exec_state;
  logic             exec;
  logic             budget_end;
  logic             accept_load;
  logic             bp_hit;

`ifdef RUN_CTRL_BREAK_EN
  // Set for the first RUN cycle after a resume so the breakpoint instruction itself executes.
  logic resume_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resume_q <= 1'b0;
    end else begin
      resume_q <= (state == S_PAUSE) && start;
    end
  end

  assign bp_hit = (state == S_RUN) && !resume_q && (pc == bp_addr);
`else
  logic unused_bp;

  assign unused_bp = ^{pc, bp_addr};
  assign bp_hit    = 1'b0;
`endif

  assign cnt_inc     = cycle_cnt + CNT_W'(1);
  assign is_halt     = (ins == HALT_INS);
  assign exec_state  = (state == S_RUN) || (state == S_STEP);
  assign exec        = exec_state && !is_halt && !bp_hit;
  assign budget_end  = (max_q != '0) && (cnt_inc == max_q);
  assign accept_load = ((state == S_IDLE) || (state == S_DONE)) && start;

  // cpu_ce stays combinational so a HALT or breakpoint is blocked in the very cycle it is fetched.
  assign cpu_ce = (state == S_LOAD) || exec;

  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        state_nx = step_mode_q ? S_PAUSE : S_RUN;
      end
      S_RUN, S_STEP: begin
        if (is_halt) begin
          state_nx = S_DONE;
        end else if (bp_hit) begin
          state_nx = S_PAUSE;
        end else if (budget_end) begin
          state_nx = S_DONE;
        end else if ((state == S_STEP) || stop) begin
          state_nx = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (start) begin
          state_nx = S_RUN;
        end else if (step) begin
          state_nx = S_STEP;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      entry_point <= '0;
      max_q       <= '0;
      step_mode_q <= 1'b0;
      int_out     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      halted      <= 1'b0;
      cycle_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state   <= state_nx;
      int_out <= (state_nx == S_LOAD);
      busy    <= (state_nx == S_LOAD) || (state_nx == S_RUN) || (state_nx == S_STEP);
      done    <= (state_nx == S_DONE);

      if (accept_load) begin
        entry_point <= entry_in;
        max_q       <= max_cycles;
        step_mode_q <= step_mode;
        cycle_cnt   <= '0;
        halted      <= 1'b0;
      end else begin
        if (exec) cycle_cnt <= cnt_inc;
        if (exec_state && is_halt) halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ychip_run_ctrl.sv
// Self-checking bench for ychip_run_ctrl: a small yChip stand-in feeds ins/pc, a behavioural model
// predicts every output each cycle, and directed scenarios pin the model with literal values.
module tb_ychip_run_ctrl;

  localparam logic [31:0] HALT = 32'h1000FFFF;
  localparam logic [31:0] NOWHERE = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        step_mode = 1'b0;
  logic        stop = 1'b0;
  logic        step = 1'b0;
  logic [31:0] entry_in = '0;
  logic [15:0] max_cycles = '0;
  logic [31:0] ins;
  logic [31:0] pc;
  logic [31:0] bp_addr = NOWHERE;
  logic [31:0] entry_point;
  logic        int_out;
  logic        cpu_ce;
  logic        busy;
  logic        done;
  logic        halted;
  logic [15:0] cycle_cnt;

  ychip_run_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .step_mode  (step_mode),
    .stop       (stop),
    .step       (step),
    .entry_in   (entry_in),
    .max_cycles (max_cycles),
    .ins        (ins),
    .pc         (pc),
    .bp_addr    (bp_addr),
    .entry_point(entry_point),
    .int_out    (int_out),
    .cpu_ce     (cpu_ce),
    .busy       (busy),
    .done       (done),
    .halted     (halted),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- yChip stand-in: pc advances by 4 per enabled cycle, INT reloads it ----------
  logic [31:0] pc_r = '0;
  logic [31:0] halt_addr = NOWHERE;
  logic        ce_seen = 1'b0;
  logic        int_seen = 1'b0;
  logic [31:0] ep_seen = '0;
  int          ce_total = 0;
  int          int_total = 0;

  assign pc  = pc_r;
  assign ins = (pc_r == halt_addr) ? HALT : {16'h2400, pc_r[15:0]};

  always @(posedge clk) begin
    if (ce_seen) pc_r <= int_seen ? ep_seen : pc_r + 32'd4;
  end

  // ---------------- behavioural model -----------------------------------------------------------
  typedef enum {M_IDLE, M_LOAD, M_RUN, M_PAUSE, M_STEP, M_DONE} mode_t;

  mode_t       m_mode = M_IDLE;
  logic [31:0] m_entry = '0;
  bit          m_limited = 1'b0;
  int          m_left = 0;
  int          m_cnt = 0;
  bit          m_halted = 1'b0;
  bit          m_stepm = 1'b0;
  bit          m_skip = 1'b0;
  bit          m_ce_now;

  function automatic bit m_bp();
`ifdef RUN_CTRL_BREAK_EN
    return (m_mode == M_RUN) && !m_skip && (pc == bp_addr);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ce();
    if (m_mode == M_LOAD) return 1'b1;
    if (m_mode == M_RUN || m_mode == M_STEP) return (ins != HALT) && !m_bp();
    return 1'b0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode    = M_IDLE;
      m_entry   = '0;
      m_limited = 1'b0;
      m_left    = 0;
      m_cnt     = 0;
      m_halted  = 1'b0;
      m_stepm   = 1'b0;
      m_skip    = 1'b0;
    end else begin
      m_ce_now = m_ce();
      case (m_mode)
        M_IDLE, M_DONE: begin
          if (start) begin
            m_entry   = entry_in;
            m_limited = (max_cycles != 16'd0);
            m_left    = int'(max_cycles);
            m_stepm   = step_mode;
            m_cnt     = 0;
            m_halted  = 1'b0;
            m_mode    = M_LOAD;
          end
        end
        M_LOAD: begin
          m_mode = m_stepm ? M_PAUSE : M_RUN;
          m_skip = 1'b0;
        end
        M_RUN, M_STEP: begin
          if (ins == HALT) begin
            m_halted = 1'b1;
            m_mode   = M_DONE;
          end else if (!m_ce_now) begin
            m_mode = M_PAUSE;
          end else begin
            m_cnt  = (m_cnt + 1) % 65536;
            m_left = m_left - 1;
            if (m_limited && m_left == 0) m_mode = M_DONE;
            else if (m_mode == M_STEP || stop) m_mode = M_PAUSE;
          end
          m_skip = 1'b0;
        end
        M_PAUSE: begin
          if (start) begin
            m_mode = M_RUN;
            m_skip = 1'b1;
          end else if (step) begin
            m_mode = M_STEP;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare against the model -----------------------------------------
  always @(negedge clk) begin
    check("cpu_ce", 32'(cpu_ce), 32'(m_ce()));
    check("int_out", 32'(int_out), 32'(m_mode == M_LOAD));
    check("busy", 32'(busy), 32'(m_mode == M_LOAD || m_mode == M_RUN || m_mode == M_STEP));
    check("done", 32'(done), 32'(m_mode == M_DONE));
    check("halted", 32'(halted), 32'(m_halted));
    check("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
    check("entry_point", entry_point, m_entry);
    ce_seen  = cpu_ce;
    int_seen = int_out;
    ep_seen  = entry_point;
    if (cpu_ce && !int_out) ce_total++;
    if (int_out) int_total++;
  end

  // ---------------- stimulus helpers ------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic [31:0] entry, input logic [15:0] max, input logic sm);
    entry_in   = entry;
    max_cycles = max;
    step_mode  = sm;
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (done) return;
      tick(1);
    end
    check({tag, "_done_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic wait_idle_busy(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (!busy) return;
      tick(1);
    end
    check({tag, "_busy_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_cnt(input string tag, input logic [15:0] value);
    for (int i = 0; i < 300; i++) begin
      if (cycle_cnt == value) return;
      tick(1);
    end
    check({tag, "_cnt_timeout"}, 32'(cycle_cnt), 32'(value));
  endtask

  int ce_mark;
  int int_mark;

  initial begin
    #1 reset = 1'b1;
    tick(2);
    check("rst_cpu_ce", 32'(cpu_ce), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt", 32'(cycle_cnt), 32'd0);
    check("rst_entry", entry_point, 32'd0);
    reset = 1'b0;
    tick(1);

    // 1: budget of 43 from entry 0x28
    ce_mark  = ce_total;
    int_mark = int_total;
    launch(32'h28, 16'd43, 1'b0);
    check("t1_int", 32'(int_out), 32'd1);
    check("t1_entry", entry_point, 32'h28);
    wait_done("t1");
    check("t1_done", 32'(done), 32'd1);
    check("t1_cnt", 32'(cycle_cnt), 32'd43);
    check("t1_halted", 32'(halted), 32'd0);
    check("t1_ce_cycles", 32'(ce_total - ce_mark), 32'd43);
    check("t1_int_pulses", 32'(int_total - int_mark), 32'd1);

    // 2: HALT at the 6th execute cycle, unlimited budget
    halt_addr = 32'h100 + 32'd20;
    ce_mark   = ce_total;
    launch(32'h100, 16'd0, 1'b0);
    wait_done("t2");
    check("t2_halted", 32'(halted), 32'd1);
    check("t2_cnt", 32'(cycle_cnt), 32'd5);
    check("t2_ce", 32'(cpu_ce), 32'd0);
    check("t2_ce_cycles", 32'(ce_total - ce_mark), 32'd5);
    halt_addr = NOWHERE;

    // 3: step mode, three single steps, then resume to a budget of 10
    launch(32'h200, 16'd10, 1'b1);
    tick(1);
    check("t3_paused", 32'(busy), 32'd0);
    ce_mark = ce_total;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(1);
    end
    check("t3_cnt", 32'(cycle_cnt), 32'd3);
    check("t3_ce_cycles", 32'(ce_total - ce_mark), 32'd3);
    int_mark = int_total;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("t3");
    check("t3_final_cnt", 32'(cycle_cnt), 32'd10);
    check("t3_no_int", 32'(int_total - int_mark), 32'd0);

    // 4: stop at cycle_cnt=10, then start+step together resumes free-running
    launch(32'h300, 16'd0, 1'b0);
    wait_cnt("t4", 16'd10);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("t4_pause_cnt", 32'(cycle_cnt), 32'd11);
    check("t4_pause_busy", 32'(busy), 32'd0);
    tick(2);
    check("t4_held_cnt", 32'(cycle_cnt), 32'd11);
    start = 1'b1;
    step  = 1'b1;
    tick(1);
    start = 1'b0;
    step  = 1'b0;
    tick(3);
    check("t4_run_cnt", 32'(cycle_cnt), 32'd14);
    check("t4_run_busy", 32'(busy), 32'd1);

    // 5: reset between edges while running
    reset = 1'b1;
    #1;
    check("t5_ce", 32'(cpu_ce), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_cnt", 32'(cycle_cnt), 32'd0);
    check("t5_entry", entry_point, 32'd0);
    tick(1);
    reset = 1'b0;
    tick(1);
    launch(32'h28, 16'd5, 1'b0);
    check("t5_reload_int", 32'(int_out), 32'd1);
    wait_done("t5");
    check("t5_cnt_after", 32'(cycle_cnt), 32'd5);

`ifdef RUN_CTRL_BREAK_EN
    // 6: breakpoint at 0x34 pauses before executing it; a step executes it
    bp_addr = 32'h34;
    launch(32'h28, 16'd0, 1'b0);
    wait_idle_busy("t6");
    check("t6_cnt", 32'(cycle_cnt), 32'd3);
    check("t6_pc", pc, 32'h34);
    check("t6_done", 32'(done), 32'd0);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(1);
    check("t6_step_cnt", 32'(cycle_cnt), 32'd4);
    bp_addr = NOWHERE;
`endif

    // random section: model checks every cycle
    for (int i = 0; i < 800; i++) begin
      start      = ($urandom_range(0, 11) == 0);
      stop       = ($urandom_range(0, 9) == 0);
      step       = ($urandom_range(0, 2) == 0);
      step_mode  = 1'($urandom_range(0, 1));
      max_cycles = 16'($urandom_range(0, 12));
      entry_in   = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 7) == 0) halt_addr = entry_in + (32'($urandom_range(0, 15)) << 2);
`ifdef RUN_CTRL_BREAK_EN
      if ($urandom_range(0, 7) == 0) bp_addr = entry_in + (32'($urandom_range(0, 15)) << 2);
`endif
      tick(1);
    end
    start = 1'b0;
    stop  = 1'b0;
    step  = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
